// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector (binary or Gray order),
// samples the DUT after a settle time and compares against an expected table.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       gray_en,
  input  logic [N_OUT*(2**N_IN)-1:0] exp_tbl,
  output logic [N_IN-1:0]            stim,
  input  logic [N_OUT-1:0]           dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN:0]              err_cnt,
  output logic                       first_err_valid,
  output logic [N_IN-1:0]            first_err_vec,
  output logic [N_OUT*(2**N_IN)-1:0] obs_tbl
);

  localparam int TBL_W = N_OUT * (2**N_IN);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     settle_cnt;
  logic [N_IN-1:0]      idx;
  logic                 gray_q;
  logic [TBL_W-1:0]     exp_q;
  logic [N_OUT-1:0]     exp_entry;
  logic                 mismatch;
  logic                 last;

  function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] i, input logic g);
    return g ? (i ^ (i >> 1)) : i;
  endfunction

  assign exp_entry = exp_q[int'(stim) * N_OUT +: N_OUT];
  assign mismatch  = (dut_out != exp_entry);
  assign last      = (idx == '1);
  assign busy      = (state == WAIT) || (state == SAMPLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = WAIT;
      WAIT:    if (settle_cnt == '0) state_next = SAMPLE;
      SAMPLE:  state_next = last ? DONE : WAIT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt      <= '0;
      idx             <= '0;
      gray_q          <= 1'b0;
      exp_q           <= '0;
      stim            <= '0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      obs_tbl         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q           <= exp_tbl;
            gray_q          <= gray_en;
            idx             <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            obs_tbl         <= '0;
            pass            <= 1'b0;
            stim            <= map_vec('0, gray_en);
            settle_cnt      <= CNT_W'(SETTLE - 1);
          end
        end
        WAIT: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        SAMPLE: begin
          obs_tbl[int'(stim) * N_OUT +: N_OUT] <= dut_out;
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= stim;
            end
          end
          if (last) begin
            // pass reflects the count including this final vector
            pass <= (err_cnt == '0) && !mismatch;
          end else begin
            idx        <= idx + 1'b1;
            stim       <= map_vec(idx + 1'b1, gray_q);
            settle_cnt <= CNT_W'(SETTLE - 1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: default instance plus a 3-in/2-out variant.
module tb_truth_table_sweeper;

  typedef struct {
    int          done_cyc;
    int          err;
    int          pass;
    int          fv;
    int          fev;
    logic [15:0] obs;
    int          last_stim;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // default instance: N_IN=4, N_OUT=1, SETTLE=2
  logic        start, gray_en;
  logic [15:0] exp_tbl, obs_tbl, dut_tbl;
  logic [3:0]  stim, first_err_vec;
  logic [0:0]  dut_out;
  logic        busy, done, pass, first_err_valid;
  logic [4:0]  err_cnt;

  // variant instance: N_IN=3, N_OUT=2, SETTLE=1
  logic        start2, gray2;
  logic [15:0] exp2, obs2, dut2_tbl;
  logic [2:0]  stim2, fev2;
  logic [1:0]  dut2_out;
  logic        busy2, done2, pass2, fv2;
  logic [3:0]  err2;

  exp_t q[$];
  exp_t q2[$];
  int   c0, c20;
  bit   sweep_active = 0;
  bit   cur_gray = 0;
  int   m_k, m_ev;
  exp_t m_e, m_e2;

  assign dut_out  = dut_tbl[stim];
  assign dut2_out = dut2_tbl[{stim2, 1'b0} +: 2];

  truth_table_sweeper u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gray_en(gray_en), .exp_tbl(exp_tbl),
    .stim(stim), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_valid(first_err_valid),
    .first_err_vec(first_err_vec), .obs_tbl(obs_tbl)
  );

  truth_table_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gray_en(gray2), .exp_tbl(exp2),
    .stim(stim2), .dut_out(dut2_out), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_err_valid(fv2), .first_err_vec(fev2), .obs_tbl(obs2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: walk the sweep order and compare table entries word by word.
  function automatic exp_t ref_sweep(input int n_in, input int n_out, input bit g,
                                     input logic [15:0] et, input logic [15:0] dt);
    exp_t r;
    int   mask = (1 << n_out) - 1;
    int   n    = 1 << n_in;
    r.err = 0; r.fv = 0; r.fev = 0; r.obs = dt; r.done_cyc = 0;
    for (int i = 0; i < n; i++) begin
      int v    = g ? (i ^ (i >> 1)) : i;
      int want = int'(et >> (v * n_out)) & mask;
      int got  = int'(dt >> (v * n_out)) & mask;
      if (want != got) begin
        r.err++;
        if (r.fv == 0) begin r.fv = 1; r.fev = v; end
      end
    end
    r.pass      = (r.err == 0) ? 1 : 0;
    r.last_stim = g ? ((n - 1) ^ ((n - 1) >> 1)) : (n - 1);
    return r;
  endfunction

  // Monitor: stim order/busy during a sweep, full result check on every done.
  always @(negedge clk) begin
    if (rst_n && sweep_active && (cyc - c0) < 48) begin
      m_k  = (cyc - c0) / 3;
      m_ev = cur_gray ? (m_k ^ (m_k >> 1)) : m_k;
      check("stim_order", int'(stim), m_ev);
      check("busy_in_sweep", int'(busy), 1);
    end
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        m_e = q.pop_front();
        check("done_cycle", cyc, m_e.done_cyc);
        check("done_busy", int'(busy), 0);
        check("err_cnt", int'(err_cnt), m_e.err);
        check("pass", int'(pass), m_e.pass);
        check("first_err_valid", int'(first_err_valid), m_e.fv);
        check("first_err_vec", int'(first_err_vec), m_e.fev);
        check("obs_tbl", int'(obs_tbl), int'(m_e.obs));
      end
    end
    if (done2) begin
      if (q2.size() == 0) begin
        check("unexpected_done2", 1, 0);
      end else begin
        m_e2 = q2.pop_front();
        check("v_done_cycle", cyc, m_e2.done_cyc);
        check("v_err_cnt", int'(err2), m_e2.err);
        check("v_pass", int'(pass2), m_e2.pass);
        check("v_first_err_valid", int'(fv2), m_e2.fv);
        check("v_first_err_vec", int'(fev2), m_e2.fev);
        check("v_obs_tbl", int'(obs2), int'(m_e2.obs));
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_stim"}, int'(stim), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_cnt), 0);
    check({tag, "_fv"}, int'(first_err_valid), 0);
    check({tag, "_fev"}, int'(first_err_vec), 0);
    check({tag, "_obs"}, int'(obs_tbl), 0);
  endtask

  // hazard: 0 none, 1 start pulse at cycle 10, 2 reset at cycle 20
  task automatic run_sweep(input bit g, input logic [15:0] et, input logic [15:0] dt,
                           input int hazard);
    exp_t e;
    exp_t dummy;
    bit   got = 0;
    dut_tbl = dt; gray_en = g; exp_tbl = et; start = 1'b1;
    @(posedge clk); #2;
    c0 = cyc; start = 1'b0; cur_gray = g; sweep_active = 1;
    e = ref_sweep(4, 1, g, et, dt);
    e.done_cyc = c0 + 48;
    q.push_back(e);
    exp_tbl = 16'($urandom); gray_en = 1'($urandom);
    for (int t = 1; t <= 200 && !got; t++) begin
      @(posedge clk); #2;
      start = (hazard == 1 && (cyc - c0) == 10);
      if (hazard == 2 && (cyc - c0) == 20) begin
        rst_n = 1'b0; sweep_active = 0;
        dummy = q.pop_back();
        @(posedge clk); #2;
        check_cleared("abort");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("abort_idle_busy", int'(busy), 0);
        return;
      end
      if (done) got = 1;
    end
    check("done_seen", int'(got), 1);
    sweep_active = 0;
    repeat (3) @(posedge clk);
    #2;
    check("hold_stim", int'(stim), e.last_stim);
    check("hold_err", int'(err_cnt), e.err);
    check("hold_pass", int'(pass), e.pass);
  endtask

  task automatic run_sweep2(input bit g, input logic [15:0] et);
    exp_t e;
    bit   got = 0;
    gray2 = g; exp2 = et; start2 = 1'b1;
    @(posedge clk); #2;
    start2 = 1'b0;
    e = ref_sweep(3, 2, g, et, dut2_tbl);
    e.done_cyc = cyc + 16;
    q2.push_back(e);
    exp2 = 16'($urandom);
    for (int t = 1; t <= 100 && !got; t++) begin
      @(posedge clk); #2;
      if (done2) got = 1;
    end
    check("v_done_seen", int'(got), 1);
    @(posedge clk); #2;
    check("v_hold_stim", int'(stim2), e.last_stim);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] par, dt, mask;
    logic [2:0]  vv;
    rst_n = 1'b0; start = 1'b1; start2 = 1'b1;
    gray_en = 1'b0; gray2 = 1'b0; exp_tbl = '0; exp2 = '0; dut_tbl = '0;
    for (int v = 0; v < 16; v++) par[v] = ^v[3:0];
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      dut2_tbl[2*v +: 2] = {vv[2] & vv[1], vv[1] ^ vv[0]};
    end

    repeat (3) begin
      @(posedge clk); #2;
      check("rst_busy", int'(busy), 0);
      check("rst_busy2", int'(busy2), 0);
    end
    check_cleared("rst");
    check("rst_err2", int'(err2), 0);
    check("rst_obs2", int'(obs2), 0);
    start = 1'b0; start2 = 1'b0; rst_n = 1'b1;
    @(posedge clk); #2;

    run_sweep(1'b0, 16'h6996, par, 0);
    run_sweep(1'b0, 16'h69B6, par, 0);
    run_sweep(1'b1, 16'h6996 ^ 16'h000C, par, 0);
    run_sweep(1'b0, 16'h6996, par, 1);
    run_sweep(1'b1, 16'h1234, par, 2);
    run_sweep(1'b0, 16'h6996, par, 0);

    for (int r = 0; r < 8; r++) begin
      dt = 16'($urandom);
      case (r % 4)
        0: mask = '0;
        1: mask = 16'(1) << $urandom_range(15, 0);
        2: mask = 16'($urandom);
        default: mask = '1;
      endcase
      run_sweep(1'($urandom), dt ^ mask, dt, (r == 5) ? 1 : 0);
    end

    run_sweep2(1'b0, dut2_tbl);
    run_sweep2(1'b1, dut2_tbl ^ 16'h0C30);
    run_sweep2(1'($urandom), dut2_tbl ^ 16'($urandom));

    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
